uart_rx_capture: RTL and testbench
==================================

Name: uart_rx_capture

Overview:
- Synthesizable UART receiver. It is the consumer stage directly downstream of the SoC UART_TX line.
- Oversamples the serial line on HCLK, reconstructs 8N1 frames and buffers the bytes in a small FIFO.
- Exposes a valid/ready byte stream plus error pulses. Used in benches and as the SoC loopback/RX path.

Parameters:
- DIV_W, 16, width of baud_div input.
- FIFO_DEPTH, 4, received-byte buffer entries (power of 2, >=2).

Ports:
- HCLK  input  1  system clock
- HRESETn  input  1  asynchronous active-low reset
- rx  input  1  serial line, idle high, asynchronous to HCLK
- baud_div  input  DIV_W  HCLK cycles per bit; values <2 treated as 2
- rx_data  output  8  FIFO head byte
- rx_valid  output  1  FIFO non-empty
- rx_ready  input  1  consumer pop; a pop occurs when rx_valid && rx_ready
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low
- overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full
- busy  output  1  high in any state except IDLE

Behaviour:
- Interface (already decided): one clock, HCLK. Reset HRESETn is asynchronous and active-low.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0. FIFO is emptied, FSM enters IDLE, synchronizer flops are set to 1.
- Synchronizer: 2-flop synchronizer on rx, giving rx_s. Edge detection uses rx_s and its previous value.
- Divisor latch: bit_len is latched from baud_div on start-edge detection. A baud_div change mid-frame has no effect until the next frame.
- State IDLE: a falling edge on rx_s moves to START and loads counter = bit_len>>1.
- State START: count down to 0, then sample rx_s.
  - rx_s=1: false start; return to IDLE with no error.
  - rx_s=0: move to DATA, counter = bit_len, bit index = 0.
- State DATA: when the counter expires, sample rx_s into a shift register, LSB first, and reload the counter. After bit 7, move to STOP.
- State STOP: when the counter expires, sample rx_s.
  - rx_s=1: push the byte and return to IDLE.
  - rx_s=0: pulse frame_err, discard the byte, move to BREAK.
- State BREAK: wait until rx_s=1, then return to IDLE. A held-low line produces exactly one frame_err.
- Sampling timing: each bit is sampled at its midpoint, i.e. (bit_len>>1) + k·bit_len cycles after the detected edge.
- Latency: a pushed byte drives rx_valid on the cycle after the stop-bit sample.
- FIFO is first-word-fall-through; rx_data is stable while rx_valid=1 and no pop occurs.
- FIFO full + push, no pop: the new byte is dropped, overrun pulses, existing contents are unchanged.
- FIFO full + push + pop in the same cycle: both happen, no overrun.
- FIFO empty + push: rx_valid rises next cycle. rx_ready while empty is ignored.
- Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full/empty use the MSB-compare rule.
- frame_err and overrun never assert in the same cycle as each other for the same frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state sits between DATA and STOP and samples one even-parity bit.
  - Adds output parity_err (1-cycle pulse) when the received parity mismatches.
  - The byte is discarded on mismatch; no frame_err unless the stop bit is also low.
- Undefined: 8N1 only, parity_err port absent, no PARITY state.

Decomposition:
- Package uart_rx_pkg:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - DATA_BITS=8, MIN_DIV=2.
- One natural sub-module: uart_rx_fifo, a synchronous FWFT FIFO with push/pop/full/empty. It is reusable by the UART TX path.

Test Plan:
- baud_div=10, send 0x55 then 0xA3 back-to-back, rx_ready=1 → rx_data 0x55 then 0xA3, each valid one cycle after its stop sample (~95 cycles after its start edge); no error pulses.
- baud_div=10, 3-cycle low glitch on idle line → returns to IDLE, no push, no frame_err, busy low again after ~5 cycles.
- baud_div=10, send 0x7E with stop bit forced 0, line then held low 50 cycles → exactly one frame_err, FIFO empty, next good frame 0x11 received correctly.
- FIFO_DEPTH=4, rx_ready=0, send 5 bytes 0x01..0x05 → 5th byte gives an overrun pulse; draining yields 0x01..0x04.
- FIFO full, rx_ready=1 asserted on the exact cycle of the 5th stop sample → no overrun, all 5 bytes read in order.
- Change baud_div 10→20 mid-frame, then assert HRESETn=0 mid-DATA → current frame decodes at 10. After reset, outputs are 0 and the FSM is IDLE; the next frame decodes at 20.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned MIN_DIV   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

endpackage

// File: rtl/uart_rx_capture_if.sv
// Received-byte stream: valid/ready handshake carrying one byte per transfer.
interface uart_rx_capture_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers for full/empty.
// A push while full is only accepted if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer advance and storage write.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  // Storage cleared on reset so the head byte reads zero while empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_capture.sv
// Oversampling UART receiver: 8N1 by default, 8E1 with parity_err when
// UART_RX_PARITY_EN is defined. Bytes land in a small FWFT FIFO.
module uart_rx_capture
  import uart_rx_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               rx,
  input  logic [DIV_W-1:0]   baud_div,
  uart_rx_capture_if.master  rx_if,
  output logic               frame_err,
  output logic               overrun,
`ifdef UART_RX_PARITY_EN
  output logic               parity_err,
`endif
  output logic               busy
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DivOne = 1;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d, bit_len_q, bit_len_d, div_eff;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 push, pop, fifo_full, fifo_empty, fall_edge, cnt_zero;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d, parity_err_q, parity_err_d;
`endif

  assign div_eff   = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
  assign fall_edge = rx_prev_q & ~rx_s_q;
  assign cnt_zero  = (cnt_q == '0);
  assign pop       = rx_if.rx_valid & rx_if.rx_ready;

  // rx is asynchronous; the previous synchronized value feeds edge detection.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Frame FSM; counters load len-1 so each sample lands at h + k*len after the edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_len_d   = bit_len_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (fall_edge) begin
          state_d   = StStart;
          bit_len_d = div_eff;
          cnt_d     = (div_eff >> 1) - DivOne;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - DivOne;
        end else if (rx_s_q) begin
          state_d = StIdle;
        end else begin
          state_d   = StData;
          cnt_d     = bit_len_q - DivOne;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - DivOne;
        end else begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d     = bit_len_q - DivOne;
          bit_idx_d = bit_idx_q + IdxW'(1);
          if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - DivOne;
        end else begin
          // Even parity: data plus parity bit must hold an even number of ones.
          par_bad_d    = ^{shift_q, rx_s_q};
          parity_err_d = ^{shift_q, rx_s_q};
          cnt_d        = bit_len_q - DivOne;
          state_d      = StStop;
        end
      end
`endif
      StStop: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - DivOne;
        end else if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
          push = ~par_bad_q;
`else
          push = 1'b1;
`endif
          state_d = StIdle;
        end else begin
          frame_err_d = 1'b1;
          state_d     = StBreak;
        end
      end
      StBreak: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    overrun_d = push & fifo_full & ~pop;
  end

  // FSM and datapath registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_len_q   <= DIV_W'(MIN_DIV);
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_len_q   <= bit_len_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_BITS)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (rx_if.rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_if.rx_valid = ~fifo_empty;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err     = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_capture.sv
// Scoreboard bench for uart_rx_capture: the sender queues each frame with the
// cycle its stop bit is sampled; the monitor keeps an ideal FIFO and checks
// every cycle against it.
module tb_uart_rx_capture;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NB = 10;
`else
  localparam int unsigned NB = 9;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        good;
    int unsigned s_cyc;
  } pend_t;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic             rx;
  logic [DIV_W-1:0] baud_div;
  logic             frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic             parity_err;
`endif
  int unsigned      cyc = 0;
  int unsigned      total = 0;
  int unsigned      bad = 0;
  int unsigned      rdy_mode;
  logic             rdy_rand = 1'b1;
  logic             exp_ferr = 1'b0;
  logic             exp_ovr = 1'b0;
  logic [7:0]       model[$];
  pend_t            pending[$];

  uart_rx_capture_if rx_if ();

  uart_rx_capture #(
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .rx         (rx),
    .baud_div   (baud_div),
    .rx_if      (rx_if),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;
  always @(posedge HCLK) begin
    #1;
    rdy_rand = ($urandom_range(0, 3) != 0);
  end
  assign rx_if.rx_ready = (rdy_mode == 2) ? rdy_rand : rdy_mode[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: ideal FWFT FIFO plus expected one-cycle error pulses.
  always @(negedge HCLK) begin
    pend_t e;
    if (!HRESETn) begin
      model.delete();
      pending.delete();
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
    end else begin
      check("rx_valid", 32'(rx_if.rx_valid), 32'(model.size() != 0));
      if (model.size() != 0) check("rx_data", 32'(rx_if.rx_data), 32'(model[0]));
      check("frame_err", 32'(frame_err), 32'(exp_ferr));
      check("overrun", 32'(overrun), 32'(exp_ovr));
`ifdef UART_RX_PARITY_EN
      check("parity_err", 32'(parity_err), 32'd0);
`endif
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      if (rx_if.rx_ready && model.size() != 0) void'(model.pop_front());
      if (pending.size() != 0 && pending[0].s_cyc == cyc) begin
        e = pending.pop_front();
        if (!e.good) exp_ferr = 1'b1;
        else if (model.size() < DEPTH) model.push_back(e.data);
        else exp_ovr = 1'b1;
      end
    end
  end

  function automatic int unsigned eff_len(input int unsigned d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int unsigned stop_cyc(input int unsigned n, input int unsigned l);
    return n + 2 + l / 2 + NB * l;
  endfunction

  // All stimulus tasks start and end just after a rising edge.
  task automatic drive_bit(input logic v, input int unsigned l);
    rx = v;
    repeat (l) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int unsigned l);
    pend_t e;
    e.data  = b;
    e.good  = stop_bit;
    e.s_cyc = stop_cyc(cyc, l);
    pending.push_back(e);
    drive_bit(1'b0, l);
    for (int i = 0; i < 8; i++) drive_bit(b[i], l);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b, l);
`endif
    drive_bit(stop_bit, l);
  endtask

  task automatic drain(input int unsigned limit);
    int unsigned k = 0;
    rdy_mode = 1;
    while ((pending.size() != 0 || model.size() != 0) && k < limit) begin
      @(posedge HCLK);
      #1;
      k++;
    end
    check("drain_done", 32'(pending.size() + model.size()), 32'd0);
    repeat (2) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n, s, l;
    HRESETn  = 1'b1;
    rx       = 1'b1;
    baud_div = 16'd10;
    rdy_mode = 1;
    #3 HRESETn = 1'b0;
    #1;
    check("rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check("rst_data", 32'(rx_if.rx_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    repeat (4) begin
      @(posedge HCLK);
      #1;
    end

    // Back-to-back bytes, always ready.
    send_frame(8'h55, 1'b1, 10);
    send_frame(8'hA3, 1'b1, 10);
    drain(50);

    // Short low glitch is a false start.
    n = cyc;
    rx = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 rx = 1'b1;
    @(negedge HCLK);
    check("glitch_busy_start", 32'(busy), 32'd1);
    repeat (4) @(posedge HCLK);
    @(negedge HCLK);
    check("glitch_busy_last", 32'(busy), 32'd1);
    @(posedge HCLK);
    @(negedge HCLK);
    check("glitch_busy_idle", 32'(busy), 32'd0);
    check("glitch_cycle", cyc, n + 8);
    @(posedge HCLK);
    #1;
    repeat (5) begin
      @(posedge HCLK);
      #1;
    end

    // Bad stop bit followed by a held-low line, then a good frame.
    send_frame(8'h7E, 1'b0, 10);
    drive_bit(1'b0, 50);
    drive_bit(1'b1, 5);
    send_frame(8'h11, 1'b1, 10);
    drain(50);

    // Five bytes with no reader: fifth one overruns.
    rdy_mode = 0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 10);
    drive_bit(1'b1, 5);
    drain(50);

    // Full FIFO, pop lands exactly on the fifth stop sample.
    rdy_mode = 0;
    for (int i = 1; i <= 4; i++) send_frame(8'(8'h20 + i), 1'b1, 10);
    n = cyc;
    s = stop_cyc(n, 10);
    fork
      send_frame(8'h25, 1'b1, 10);
      begin
        repeat (s - n) @(posedge HCLK);
        #1 rdy_mode = 1;
        @(posedge HCLK);
        #1 rdy_mode = 0;
      end
    join
    drain(50);

    // Divisor change mid-frame, then reset in the middle of the next frame.
    rdy_mode = 0;
    fork
      send_frame(8'h3C, 1'b1, 10);
      begin
        repeat (40) @(posedge HCLK);
        #1 baud_div = 16'd20;
      end
    join
    drive_bit(1'b1, 5);
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 20);
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 20);
    HRESETn = 1'b0;
    rx = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check("mid_rst_data", 32'(rx_if.rx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    repeat (5) begin
      @(posedge HCLK);
      #1;
    end
    check("post_rst_busy", 32'(busy), 32'd0);
    rdy_mode = 1;
    send_frame(8'h96, 1'b1, 20);
    drain(80);

    // Random frames, divisors (including values below two) and reader stalls.
    rdy_mode = 2;
    for (int i = 0; i < 14; i++) begin
      baud_div = 16'($urandom_range(0, 12));
      l = eff_len(32'(baud_div));
      if ($urandom_range(0, 5) == 0) begin
        send_frame(8'($urandom), 1'b0, l);
        drive_bit(1'b0, $urandom_range(0, l));
      end else begin
        send_frame(8'($urandom), 1'b1, l);
      end
      drive_bit(1'b1, 3 + $urandom_range(0, 4));
    end
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
